// File: rtl/seven_seg_scan_ctrl_if.sv
// Load channel of the 7-segment scan controller: packed BCD word with valid/ready.
// Nibble [3:0] is digit 0 (rightmost).
interface seven_seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller feeding one shared BCD decoder, with a
// double-buffered load committed at frame start. Optional macro LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seven_seg_scan_ctrl_if.slave  load,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned BufW   = 4 * NUM_DIGITS;

  typedef enum logic {StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [BufW-1:0]       pend_q, pend_d;
  logic [BufW-1:0]       disp_q, disp_d;
  logic [BufW-1:0]       commit_val;
  logic [NUM_DIGITS-1:0] dig_en_d;
  logic [3:0]            bcd_d;
  logic                  at_frame_start;
  logic                  commit;
  logic                  accept;

  assign at_frame_start = enable && (state_q == StBlank) && (idx_q == '0) && (cnt_q == '0);
  assign commit         = at_frame_start && pending_q;
  assign accept         = load.load_valid && !pending_q;
  assign load.load_ready = !pending_q;
  // Reset state already looks like a frame start; keep the strobe quiet while held in reset.
  assign frame_start    = rst_n && at_frame_start;

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_lead;
  always_comb begin
    commit_val = pend_q;
    lz_lead    = 1'b1;
    // Digit 0 is excluded so a value of zero still shows "0".
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (lz_lead && (pend_q[4*i +: 4] == 4'h0)) begin
        commit_val[4*i +: 4] = 4'hF;
      end else begin
        lz_lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    commit_val = pend_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = StBlank;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StBlank;
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    pend_d    = pend_q;
    disp_d    = disp_q;
    if (accept) begin
      pend_d    = load.load_data;
      pending_d = 1'b1;
    end
    if (commit) begin
      disp_d    = commit_val;
      pending_d = 1'b0;
    end
  end

  // Outputs are registered from next state so they line up with state_q.
  always_comb begin
    dig_en_d = '0;
    bcd_d    = 4'hF;
    if (state_d == StShow) begin
      dig_en_d = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_d;
      bcd_d    = disp_d[{idx_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StBlank;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pend_q    <= {NUM_DIGITS{4'hF}};
      disp_q    <= {NUM_DIGITS{4'hF}};
      dig_en    <= '0;
      bcd_out   <= 4'hF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      dig_en    <= dig_en_d;
      bcd_out   <= bcd_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares. Honours LEADING_ZERO_BLANK_EN if defined.
module tb_seven_seg_scan_ctrl;
  localparam int unsigned ND = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] Lz0050 = 16'hFF50;
  localparam logic [15:0] Lz0000 = 16'hFFF0;
`else
  localparam logic [15:0] Lz0050 = 16'h0050;
  localparam logic [15:0] Lz0000 = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [3:0]    bcd_out;
  logic [ND-1:0] dig_en;
  logic          frame_start;
  string         phase = "reset";

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (lif),
    .bcd_out    (bcd_out),
    .dig_en     (dig_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [3:0] bcd;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs for n cycles of a frame starting at its first blank cycle.
  // Frame = per digit: 2 blank cycles then 4 lit cycles. r0/r1 = ready in cycles 0/1.
  task automatic push_frame(input logic [15:0] disp, input logic r0, input logic r1,
                            input logic rr, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   k;
      k = i / 6;
      if ((i % 6) < 2) begin
        e.dig = 4'b0000;
        e.bcd = 4'hF;
      end else begin
        e.dig = 4'(1 << k);
        e.bcd = disp[4*k +: 4];
      end
      e.fs  = (i == 0);
      e.rdy = (i == 0) ? r0 : ((i == 1) ? r1 : rr);
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.dig = 4'b0000;
    e.bcd = 4'hF;
    e.fs  = 1'b0;
    e.rdy = 1'b1;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (dig_en !== e.dig || bcd_out !== e.bcd || frame_start !== e.fs ||
          lif.load_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s t=%0t: got dig_en=%b bcd=%h fs=%b rdy=%b, want dig_en=%b bcd=%h fs=%b rdy=%b",
                 phase, $time, dig_en, bcd_out, frame_start, lif.load_ready,
                 e.dig, e.bcd, e.fs, e.rdy);
      end
    end
  end

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    // Held reset with enable=1: dark, ready, no frame strobe.
    push_idle(4);
    step(5);

    // Load while disabled, then enable: commit happens in the first blank cycle.
    rst_n = 1'b1;
    enable = 1'b0;
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1234;
    step(1);
    lif.load_valid = 1'b0;
    enable = 1'b1;
    phase = "scan1234";
    push_frame(16'h1234, 1'b0, 1'b1, 1'b1, 24);
    push_frame(16'h1234, 1'b1, 1'b1, 1'b1, 24);
    step(48);

    // Back-pressure: 1111 taken, 2222 held until the cycle after the next commit.
    phase = "backpressure";
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1111;
    push_frame(16'h1234, 1'b1, 1'b0, 1'b0, 24);
    push_frame(16'h1111, 1'b0, 1'b1, 1'b0, 24);
    push_frame(16'h2222, 1'b0, 1'b1, 1'b1, 24);
    step(1);
    lif.load_data = 16'h2222;
    step(25);
    lif.load_valid = 1'b0;
    step(46);

    // Disable during SHOW of digit 2, then restart at digit 0 with the same buffer.
    phase = "enable";
    push_frame(16'h2222, 1'b1, 1'b1, 1'b1, 16);
    push_idle(3);
    step(15);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    push_frame(16'h2222, 1'b1, 1'b1, 1'b1, 24);
    step(24);

    // Zero nibbles, with or without leading-zero blanking.
    phase = "zeros";
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h0050;
    push_frame(16'h2222, 1'b1, 1'b0, 1'b0, 24);
    push_frame(Lz0050, 1'b0, 1'b1, 1'b0, 24);
    push_frame(Lz0000, 1'b0, 1'b1, 1'b1, 24);
    step(1);
    lif.load_valid = 1'b0;
    step(24);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h0000;
    step(1);
    lif.load_valid = 1'b0;
    step(46);

    // Reset mid-SHOW with a load pending: display and pending buffer both cleared.
    phase = "reset_mid";
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1234;
    push_frame(Lz0000, 1'b1, 1'b0, 1'b0, 4);
    push_idle(1);
    step(1);
    lif.load_valid = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    push_frame(16'hFFFF, 1'b1, 1'b1, 1'b1, 24);
    step(24);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
